// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: funct3 encodings,
// FSM state encoding and the captured-request record.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Upper bound on the byte-address width the captured request can hold.
    localparam int DMEM_ADDR_W_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic                       we;
        logic [DMEM_ADDR_W_MAX-1:0] addr;
        logic [31:0]                wdata;
        logic [2:0]                 funct3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: per-byte store enables/data and load extension by funct3.
// DMEM_MISALIGN_TRAP_EN turns misaligned or unsupported accesses into errors.
import dmem_pkg::*;

module dmem_lane_fmt (
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] ld_raw,
    output logic [3:0]  byte_we,
    output logic [31:0] byte_wd,
    output logic [31:0] ld_data,
    output logic        err
);

    logic [3:0]  st_en;
    logic [31:0] ld_ext;
    logic        misaligned;
    logic        st_bad;
    logic        ld_bad;
    logic        fault;

    always_comb begin
        st_en      = 4'b0000;
        ld_ext     = 32'h0;
        misaligned = 1'b0;
        st_bad     = 1'b0;
        ld_bad     = 1'b0;
        case (funct3)
            F3_B:  begin
                st_en  = 4'b0001;
                ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
            end
            F3_H:  begin
                st_en      = 4'b0011;
                ld_ext     = {{16{ld_raw[15]}}, ld_raw[15:0]};
                misaligned = addr_lo[0];
            end
            F3_W:  begin
                st_en      = 4'b1111;
                ld_ext     = ld_raw;
                misaligned = |addr_lo;
            end
            F3_BU: begin
                ld_ext = {24'h0, ld_raw[7:0]};
                st_bad = 1'b1;
            end
            F3_HU: begin
                ld_ext     = {16'h0, ld_raw[15:0]};
                misaligned = addr_lo[0];
                st_bad     = 1'b1;
            end
            default: begin
                st_bad = 1'b1;
                ld_bad = 1'b1;
            end
        endcase
        fault = misaligned | (we ? st_bad : ld_bad);
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign err = fault;
`else
    logic fault_unused;
    assign fault_unused = fault;
    assign err          = 1'b0;
`endif

    // An erroring access neither writes nor returns data.
    assign byte_we = (we && !err) ? st_en : 4'b0000;
    assign byte_wd = wdata;
    assign ld_data = (we || err) ? 32'h0 : ld_ext;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with WAIT_CYC wait states between request and response.
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
import dmem_pkg::*;

module dmem_responder #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int WAIT_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and response payload is held until accepted.

    dmem_state_t           state, state_nxt;
    logic [3:0]            wait_cnt;
    dmem_req_t             req_q, req_cur;
    logic [7:0]            mem [2**DM_ADDRESS];
    logic [DM_ADDRESS-1:0] base_addr;
    logic [DM_ADDRESS-1:0] byte_addr [4];
    logic [31:0]           ld_raw, ld_data, byte_wd;
    logic [3:0]            byte_we;
    logic                  commit, fmt_err;
    logic [31:0]           rdata_q;
    logic                  err_q;

    // With zero wait states the commit edge is the acceptance edge, so the live inputs are used.
    always_comb begin
        if (state == ST_IDLE) begin
            req_cur.we     = req_we;
            req_cur.addr   = DMEM_ADDR_W_MAX'(req_addr);
            req_cur.wdata  = req_wdata;
            req_cur.funct3 = req_funct3;
        end else begin
            req_cur = req_q;
        end
    end

    assign base_addr = req_cur.addr[DM_ADDRESS-1:0];

    generate
        if (DM_ADDRESS < DMEM_ADDR_W_MAX) begin : g_addr_hi
            logic addr_hi_unused;
            assign addr_hi_unused = ^req_cur.addr[DMEM_ADDR_W_MAX-1:DM_ADDRESS];
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            byte_addr[i]     = base_addr + DM_ADDRESS'(i);
            ld_raw[8*i +: 8] = mem[byte_addr[i]];
        end
    end

    dmem_lane_fmt u_lane_fmt (
        .we      (req_cur.we),
        .funct3  (req_cur.funct3),
        .addr_lo (req_cur.addr[1:0]),
        .wdata   (req_cur.wdata),
        .ld_raw  (ld_raw),
        .byte_we (byte_we),
        .byte_wd (byte_wd),
        .ld_data (ld_data),
        .err     (fmt_err)
    );

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYC == 0) begin
                        state_nxt = ST_RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                    commit    = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            req_q    <= '0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req_valid) begin
                req_q <= req_cur;
                if (WAIT_CYC > 0) wait_cnt <= 4'(WAIT_CYC - 1);
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) begin
                rdata_q <= ld_data;
                err_q   <= fmt_err;
            end
        end
    end

    // Storage is not reset; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_we[i]) mem[byte_addr[i]] <= byte_wd[8*i +: 8];
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (WAIT_CYC=2, DM_ADDRESS=9).
// Expectations follow DMEM_MISALIGN_TRAP_EN when the bench is built with it.
module tb_dmem_responder;

    localparam int WAIT_CYC = 2;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYC(WAIT_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                                    input logic [2:0] f3, input logic [31:0] rd_plain,
                                    input logic [31:0] rd_trap, input logic err_trap);
        vec_t v;
        v.we    = we;
        v.addr  = addr;
        v.wdata = wdata;
        v.f3    = f3;
`ifdef DMEM_MISALIGN_TRAP_EN
        v.exp_rd  = rd_trap;
        v.exp_err = err_trap;
`else
        v.exp_rd  = rd_plain;
        v.exp_err = 1'b0;
        if (err_trap && rd_trap != 32'h0) v.exp_err = 1'b0;
`endif
        vecs.push_back(v);
    endfunction

    // driver: one full request/response transaction, holding rsp_ready low for 'hold' cycles
    task automatic do_req(input string name, input logic we, input logic [8:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        req_funct3 = f3;
        @(negedge clk);
        // scramble request inputs: only the captured copy may matter
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_addr   = 9'($urandom_range(0, 511));
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(WAIT_CYC + 1));
        if (!rsp_valid) return;
        check({name, "_rdata"}, rsp_rdata, exp_rd);
        check({name, "_err"}, 32'(rsp_err), 32'(exp_err));
        check({name, "_ready_in_resp"}, 32'(req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({name, "_hold_rdata"}, rsp_rdata, exp_rd);
            check({name, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_valid_after"}, 32'(rsp_valid), 32'd0);
        check({name, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 9'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b0;
        rsp_ready  = 1'b0;

        //             we    addr    wdata         f3      plain         trap          err_trap
        add_vec(1'b1, 9'h010, 32'hDEADBEEF, LW,     32'h0,        32'h0,        1'b0);
        add_vec(1'b0, 9'h010, 32'h0,        LW,     32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        add_vec(1'b0, 9'h010, 32'h0,        LB,     32'hFFFFFFEF, 32'hFFFFFFEF, 1'b0);
        add_vec(1'b0, 9'h010, 32'h0,        LBU,    32'h000000EF, 32'h000000EF, 1'b0);
        add_vec(1'b0, 9'h012, 32'h0,        LH,     32'hFFFFDEAD, 32'hFFFFDEAD, 1'b0);
        add_vec(1'b0, 9'h012, 32'h0,        LHU,    32'h0000DEAD, 32'h0000DEAD, 1'b0);
        add_vec(1'b1, 9'h020, 32'h00000000, LW,     32'h0,        32'h0,        1'b0);
        add_vec(1'b1, 9'h021, 32'hFFFFFFA5, LB,     32'h0,        32'h0,        1'b0);
        add_vec(1'b0, 9'h020, 32'h0,        LW,     32'h0000A500, 32'h0000A500, 1'b0);
        add_vec(1'b1, 9'h024, 32'hFFFFFFFF, LW,     32'h0,        32'h0,        1'b0);
        add_vec(1'b1, 9'h024, 32'hAAAA8001, LH,     32'h0,        32'h0,        1'b0);
        add_vec(1'b0, 9'h024, 32'h0,        LW,     32'hFFFF8001, 32'hFFFF8001, 1'b0);
        add_vec(1'b0, 9'h024, 32'h0,        LH,     32'hFFFF8001, 32'hFFFF8001, 1'b0);
        add_vec(1'b0, 9'h024, 32'h0,        LHU,    32'h00008001, 32'h00008001, 1'b0);
        add_vec(1'b0, 9'h025, 32'h0,        LB,     32'hFFFFFF80, 32'hFFFFFF80, 1'b0);
        add_vec(1'b0, 9'h025, 32'h0,        LBU,    32'h00000080, 32'h00000080, 1'b0);
        add_vec(1'b0, 9'h010, 32'h0,        3'b011, 32'h0,        32'h0,        1'b1);
        add_vec(1'b0, 9'h010, 32'h0,        3'b110, 32'h0,        32'h0,        1'b1);
        add_vec(1'b1, 9'h010, 32'h0,        3'b011, 32'h0,        32'h0,        1'b1);
        add_vec(1'b0, 9'h010, 32'h0,        LW,     32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        add_vec(1'b1, 9'h030, 32'h00000000, LW,     32'h0,        32'h0,        1'b0);
        add_vec(1'b1, 9'h1FE, 32'h00000011, LB,     32'h0,        32'h0,        1'b0);
        add_vec(1'b1, 9'h1FF, 32'h00000022, LB,     32'h0,        32'h0,        1'b0);
        add_vec(1'b1, 9'h000, 32'h00000033, LB,     32'h0,        32'h0,        1'b0);
        add_vec(1'b1, 9'h001, 32'h00000044, LB,     32'h0,        32'h0,        1'b0);
        add_vec(1'b0, 9'h1FE, 32'h0,        LW,     32'h44332211, 32'h0,        1'b1);
        add_vec(1'b0, 9'h1FF, 32'h0,        LH,     32'h00003322, 32'h0,        1'b1);
        add_vec(1'b0, 9'h1FF, 32'h0,        LBU,    32'h00000022, 32'h00000022, 1'b0);
        add_vec(1'b1, 9'h040, 32'h00000000, LW,     32'h0,        32'h0,        1'b0);
        add_vec(1'b1, 9'h044, 32'h00000000, LW,     32'h0,        32'h0,        1'b0);
        add_vec(1'b1, 9'h041, 32'h11223344, LW,     32'h0,        32'h0,        1'b1);
        add_vec(1'b0, 9'h040, 32'h0,        LW,     32'h22334400, 32'h0,        1'b0);
        add_vec(1'b0, 9'h044, 32'h0,        LW,     32'h00000011, 32'h0,        1'b0);

        // reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
                   vecs[i].exp_rd, vecs[i].exp_err, 0);
        end

        // backpressure: rsp_ready held low for 5 cycles
        do_req("bp_lw", 1'b0, 9'h010, 32'h0, LW, 32'hDEADBEEF, 1'b0, 5);

        // reset while a store is in WAIT: store must be dropped
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 9'h030;
        req_wdata  = 32'h12345678;
        req_funct3 = LW;
        @(negedge clk);
        req_valid = 1'b0;
        check("midwait_req_ready", 32'(req_ready), 32'd0);
        check("midwait_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midwait_post_rst_valid", 32'(rsp_valid), 32'd0);
        check("midwait_post_rst_ready", 32'(req_ready), 32'd1);
        check("midwait_post_rst_rdata", rsp_rdata, 32'h0);
        repeat (4) begin
            @(negedge clk);
            check("midwait_no_late_rsp", 32'(rsp_valid), 32'd0);
        end
        do_req("midwait_lw", 1'b0, 9'h030, 32'h0, LW, 32'h0, 1'b0, 0);
        do_req("neighbor_lw", 1'b0, 9'h010, 32'h0, LW, 32'hDEADBEEF, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory request interface: accepts load/store requests from the MEM stage through a valid/ready handshake and returns one response per request.
- Adds a configurable number of wait states so the pipeline can be tested against a slow memory.
- Memory is a little-endian byte array. Loads are sized and sign- or zero-extended per funct3; stores are sized per funct3.
- Sits between the MEM-stage request signals (write enable, read enable, address, write data, funct3) and storage, in place of a fixed-latency memory.

Parameters:
- DM_ADDRESS, 9, byte-address width; memory holds 2^DM_ADDRESS bytes.
- DATA_W, 32, data width; must be 32.
- WAIT_CYC, 2, wait states between request acceptance and response (0..15).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  DM_ADDRESS  byte address.
- req_wdata  input  DATA_W  store data; low bytes are used for SB/SH.
- req_funct3  input  3  access size/sign (RV32I load/store encoding).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  DATA_W  load result; 0 for stores.
- rsp_err  output  1  access error; only present when MISALIGN_TRAP_EN is defined, otherwise tied 0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory contents are not altered by reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, capture we/addr/wdata/funct3. Go to WAIT with counter=WAIT_CYC-1 if WAIT_CYC>0; otherwise go straight to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle. At counter==0, go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE. req_ready is not asserted in the same cycle.
- Commit point: the memory write and the load sample both occur on the clock edge that enters RESP.
  - Latency from the acceptance edge to rsp_valid high = WAIT_CYC+1 cycles.
  - A store is visible to any later request.
- Stores:
  - funct3 000: writes byte addr.
  - funct3 001: writes bytes addr, addr+1.
  - funct3 010: writes bytes addr..addr+3.
  - Other funct3 values: no write.
- Loads:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
  - Other funct3 values return 0.
- Byte order: little-endian; the byte at addr is the least significant byte.
- Address wrap: multi-byte accesses wrap modulo 2^DM_ADDRESS. Example, DM_ADDRESS=9: an LW at addr 0x1FE reads bytes 0x1FE, 0x1FF, 0x000, 0x001.
- Misaligned accesses (without the feature) complete normally, byte by byte.
- Reset mid-operation: the captured request is discarded. A store still in WAIT is not written. The FSM returns to IDLE.
- Input changes while not in IDLE are ignored; only the captured copy is used.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0]!=0, or a word access with addr[1:0]!=0, produces rsp_err=1 and rsp_rdata=0.
  - An erroring store performs no write.
  - Latency is unchanged.
  - An unsupported funct3 also sets rsp_err.
- Undefined: rsp_err is constant 0; misaligned accesses complete with wrap rules.

Decomposition:
- Shared package dmem_pkg holds:
  - the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the FSM state enum dmem_state_t;
  - the captured-request struct dmem_req_t (we, addr, wdata, funct3).
- Sub-module dmem_lane_fmt: combinational. Builds per-byte write enables and byte data from funct3/addr/wdata, and extends the loaded data from funct3. Instantiated once.

Test Plan:
- Word round-trip, WAIT_CYC=2: SW addr 0x010, data 0xDEADBEEF, then LW 0x010 -> rsp_rdata=0xDEADBEEF; rsp_valid rises exactly 3 cycles after each acceptance.
- Sized loads after the SW above: LB 0x010 -> 0xFFFFFFEF; LBU 0x010 -> 0x000000EF; LH 0x012 -> 0xFFFFDEAD; LHU 0x012 -> 0x0000DEAD.
- Byte store merge: SW 0x020 data 0x00000000, then SB 0x021 data 0x000000A5, then LW 0x020 -> 0x0000A500.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready=0; when rsp_ready=1 the handshake completes and req_ready=1 on the next cycle.
- Reset mid-WAIT: issue SW 0x030 data 0x12345678, assert reset during WAIT, then LW 0x030 -> old contents (pre-loaded 0x0), not 0x12345678; rsp_valid=0 and req_ready=1 right after reset.
- Wrap and misalign: LW 0x1FE after preloading bytes 0x1FE=0x11, 0x1FF=0x22, 0x000=0x33, 0x001=0x44 -> 0x44332211 without the macro; with DMEM_MISALIGN_TRAP_EN -> rsp_err=1, rsp_rdata=0.
